// File: rtl/alsu_pkg.sv
// Shared types and helpers for the ALSU request scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alsu_pkg;

  localparam int CTRL_W = 7;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  // Control word packing: {cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B}
  localparam int CTRL_CIN     = 6;
  localparam int CTRL_SI      = 5;
  localparam int CTRL_SH_LEFT = 4;
  localparam int CTRL_RED_A   = 3;
  localparam int CTRL_RED_B   = 2;
  localparam int CTRL_PASS_A  = 1;
  localparam int CTRL_PASS_B  = 0;

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } tag_t;

  // Opcodes 6/7 do not exist; reduction modes only apply to AND/XOR.
  function automatic logic is_illegal(input logic [2:0] op, input logic [CTRL_W-1:0] ctrl);
    logic red;
    red = ctrl[CTRL_RED_A] | ctrl[CTRL_RED_B];
    return (op > OP_ROT) || (red && (op != OP_AND) && (op != OP_XOR));
  endfunction

endpackage

// File: rtl/alsu_sched_rr_arb2.sv
// Two-way round-robin arbiter; the last winner loses the next tie.
// Latency: combinational grant, winner state updates on the grant edge.
// Backpressure: grant is the ready; no grant while rstn is low.
// Ports: clk, rstn, valid_i[1:0] request lines, gnt_o[1:0] one-hot grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt_o      = 2'b00;
    last_gnt_d = last_gnt_q;
    if (rstn) begin
      if (valid_i == 2'b11) begin
        gnt_o = last_gnt_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = valid_i;
      end
    end
    if (gnt_o != 2'b00) begin
      last_gnt_d = gnt_o[1];
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/alsu_sched.sv
// Shares one ALSU between two requesters: arbitrate, issue, tag, return results.
// Latency: response pulse ALSU_LAT+2 edges after the accept edge; 1 req/cycle.
// Backpressure: reqN_ready is the grant; responses have no backpressure.
// Ports: reqN_* request channels, alsu_* drive/return the ALSU, rsp_* tagged results.
module alsu_sched
  import alsu_pkg::*;
#(
  parameter int BITS     = 3,
  parameter int ALSU_LAT = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [2:0]          req0_op,
  input  logic [BITS-1:0]     req0_a,
  input  logic [BITS-1:0]     req0_b,
  input  logic [CTRL_W-1:0]   req0_ctrl,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [2:0]          req1_op,
  input  logic [BITS-1:0]     req1_a,
  input  logic [BITS-1:0]     req1_b,
  input  logic [CTRL_W-1:0]   req1_ctrl,
  output logic [2:0]          alsu_opcode,
  output logic [BITS-1:0]     alsu_A,
  output logic [BITS-1:0]     alsu_B,
  output logic [CTRL_W-1:0]   alsu_ctrl,
  input  logic [2*BITS-1:0]   alsu_out,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [2*BITS-1:0]   rsp_data,
  output logic                rsp_err
);

  logic [1:0] gnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i ({req1_valid, req0_valid}),
    .gnt_o   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  logic [2:0]        op_q,   op_d;
  logic [BITS-1:0]   a_q,    a_d;
  logic [BITS-1:0]   b_q,    b_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  tag_t              issue_tag_q, issue_tag_d;

  // The issue tag travels alongside the operand register so that tag_q[0]
  // lines up with the ALSU sampling edge; the pipe then mirrors ALSU_LAT.
  always_comb begin
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    issue_tag_d = '0;
    if (gnt[1]) begin
      op_d        = req1_op;
      a_d         = req1_a;
      b_d         = req1_b;
      ctrl_d      = req1_ctrl;
      issue_tag_d = '{valid: 1'b1, id: 1'b1, err: is_illegal(req1_op, req1_ctrl)};
    end else if (gnt[0]) begin
      op_d        = req0_op;
      a_d         = req0_a;
      b_d         = req0_b;
      ctrl_d      = req0_ctrl;
      issue_tag_d = '{valid: 1'b1, id: 1'b0, err: is_illegal(req0_op, req0_ctrl)};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      issue_tag_q <= '0;
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      issue_tag_q <= issue_tag_d;
    end
  end

  assign alsu_opcode = op_q;
  assign alsu_A      = a_q;
  assign alsu_B      = b_q;
  assign alsu_ctrl   = ctrl_q;

  // Tag pipe: stage 0 loads on the ALSU sample edge, the tail coincides
  // with a valid alsu_out.
  tag_t tag_q [0:ALSU_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= ALSU_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= issue_tag_q;
      for (int i = 1; i <= ALSU_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q,    rsp_id_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [2*BITS-1:0] rsp_data_q,  rsp_data_d;

  always_comb begin
    rsp_valid_d = tag_q[ALSU_LAT].valid;
    rsp_id_d    = tag_q[ALSU_LAT].id;
    rsp_err_d   = tag_q[ALSU_LAT].err;
    rsp_data_d  = rsp_data_q;
    if (tag_q[ALSU_LAT].valid) begin
      rsp_data_d = alsu_out;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule
